alu_exec_unit: RTL



---
 rtl/alu_exec_unit_pkg.sv | 91 +++++++++
 rtl/alu_exec_unit_mul_div_iter.sv | 127 ++++++++++++
 rtl/alu_exec_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the ALU execute stage: ALUOp/Funct codes, internal op enum,
// mult/div FSM states and the opcode decoder.
package alu_exec_unit_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO
  } alu_op_e;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    is_md;
    logic    md_div;
    logic    md_signed;
    logic    illegal;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] aluop, input logic [5:0] funct);
    dec_t d;
    d.op        = OP_ADD;
    d.is_md     = 1'b0;
    d.md_div    = 1'b0;
    d.md_signed = 1'b0;
    d.illegal   = 1'b0;
    case (aluop)
      ALUOP_ADD: d.op = OP_ADD;
      ALUOP_SUB: d.op = OP_SUB;
      ALUOP_AND: d.op = OP_AND;
      ALUOP_OR:  d.op = OP_OR;
      ALUOP_SLT: d.op = OP_SLT;
      ALUOP_LUI: d.op = OP_LUI;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:   d.op = OP_ADD;
          FN_ADDU:  d.op = OP_ADDU;
          FN_SUB:   d.op = OP_SUB;
          FN_SUBU:  d.op = OP_SUBU;
          FN_AND:   d.op = OP_AND;
          FN_OR:    d.op = OP_OR;
          FN_XOR:   d.op = OP_XOR;
          FN_NOR:   d.op = OP_NOR;
          FN_SLT:   d.op = OP_SLT;
          FN_SLTU:  d.op = OP_SLTU;
          FN_SLL:   d.op = OP_SLL;
          FN_SRL:   d.op = OP_SRL;
          FN_SRA:   d.op = OP_SRA;
          FN_MFHI:  d.op = OP_MFHI;
          FN_MFLO:  d.op = OP_MFLO;
          FN_MULT:  begin d.is_md = 1'b1; d.md_signed = 1'b1; end
          FN_MULTU: d.is_md = 1'b1;
          FN_DIV:   begin d.is_md = 1'b1; d.md_div = 1'b1; d.md_signed = 1'b1; end
          FN_DIVU:  begin d.is_md = 1'b1; d.md_div = 1'b1; end
          default:  d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul_div_iter.sv
// Iterative multiply/divide engine: WIDTH shift-add or restoring-subtract steps on
// operand magnitudes, then one FIX cycle that applies signs and presents HI/LO.
module mul_div_iter
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d, opb_q, opb_d, a_raw_q, a_raw_d;
  logic             div_q, div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d, bzero_q, bzero_d;

  logic             a_neg, b_neg;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;

  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    a_raw_d = a_raw_q;
    div_d   = div_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    bzero_d = bzero_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          acc_d   = '0;
          lo_d    = a_neg ? -a : a;
          opb_d   = b_neg ? -b : b;
          a_raw_d = a;
          div_d   = is_div;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          bzero_d = (b == '0);
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        if (div_q) begin
          // restoring step: keep the trial difference only when it did not borrow
          acc_d = div_diff[WIDTH] ? div_shift : div_diff;
          lo_d  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = {1'b0, mul_sum[WIDTH:1]};
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = MD_FIX;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    prod = {acc_q[WIDTH-1:0], lo_q};
    hi   = '0;
    lo   = '0;
    if (!div_q) begin
      if (neg_a_q ^ neg_b_q) prod = -prod;
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end else if (bzero_q) begin
      hi = a_raw_q;
      lo = '1;
    end else begin
      lo = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
      hi = neg_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  assign done = (state_q == MD_FIX);
  assign div0 = div_q & bzero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      a_raw_q <= a_raw_d;
      div_q   <= div_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      bzero_q <= bzero_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// MIPS ALU execute stage: single-cycle ops registered at the accept edge, plus an
// iterative mult/div engine with HI/LO that stalls upstream through in_ready.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         ALUOp,
  input  logic [5:0]         Funct,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               div0,
  output logic               illegal,
  output logic               out_valid,
  output logic               busy
);

  dec_t             dec;
  logic             accept, md_done, md_div0;
  logic [WIDTH-1:0] md_hi, md_lo, alu_res, sum, diff;
  logic             alu_ovf;

  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, overflow_q, overflow_d, div0_q, div0_d;
  logic             illegal_q, illegal_d, out_valid_q, out_valid_d, busy_q, busy_d;

  assign dec    = decode(ALUOp, Funct);
  assign accept = in_valid && !busy_q;
  assign sum    = A + B;
  assign diff   = A - B;

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (accept && dec.is_md),
    .is_div    (dec.md_div),
    .is_signed (dec.md_signed),
    .a         (A),
    .b         (B),
    .done      (md_done),
    .hi        (md_hi),
    .lo        (md_lo),
    .div0      (md_div0)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (dec.op)
      OP_ADD:  begin alu_res = sum;  alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]); end
      OP_ADDU: alu_res = sum;
      OP_SUB:  begin alu_res = diff; alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]); end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  alu_res = B << shamt;
      OP_SRL:  alu_res = B >> shamt;
      OP_SRA:  alu_res = $signed(B) >>> shamt;
      OP_LUI:  alu_res = B << 16;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    div0_d      = div0_q;
    illegal_d   = illegal_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    if (md_done) begin
      hi_d        = md_hi;
      lo_d        = md_lo;
      result_d    = md_lo;
      zero_d      = (md_lo == '0);
      overflow_d  = 1'b0;
      illegal_d   = 1'b0;
      div0_d      = md_div0;
      out_valid_d = 1'b1;
      busy_d      = 1'b0;
    end else if (accept) begin
      if (dec.illegal) begin
        result_d    = '0;
        zero_d      = 1'b1;
        overflow_d  = 1'b0;
        illegal_d   = 1'b1;
        div0_d      = 1'b0;
        out_valid_d = 1'b1;
      end else if (dec.is_md) begin
        busy_d = 1'b1;
      end else begin
        result_d    = alu_res;
        zero_d      = (alu_res == '0);
        overflow_d  = alu_ovf;
        illegal_d   = 1'b0;
        div0_d      = 1'b0;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign div0      = div0_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = !busy_q;

endmodule
